// File: rtl/inst_fetch_mem.sv
// Instruction fetch memory: DEPTH x 16-bit program store with a load port and
// a one-entry registered fetch response returning FETCH_W consecutive words.
// Lanes that fall past the end of the store return NOP_WORD with mask bit 0.
module inst_fetch_mem #(
  parameter int          DEPTH    = 256,
  parameter int          ADDR_W   = 16,
  parameter int          FETCH_W  = 2,
  parameter logic [15:0] NOP_WORD = 16'hFFFF
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_ld_en,
  input  logic [ADDR_W-1:0]      i_ld_addr,
  input  logic [15:0]            i_ld_data,
  input  logic                   i_req_valid,
  input  logic [ADDR_W-1:0]      i_req_addr,
  output logic                   o_req_ready,
  input  logic                   i_flush,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [16*FETCH_W-1:0]  o_rsp_data,
  output logic [FETCH_W-1:0]     o_rsp_mask,
  output logic [ADDR_W-1:0]      o_rsp_addr
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Store depth at one bit wider than an address, so base+lane never wraps.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_accept;
  logic [16*FETCH_W-1:0]  w_fetch_data;
  logic [FETCH_W-1:0]     w_fetch_mask;
  logic [16*FETCH_W-1:0]  r_rsp_data;
  logic [FETCH_W-1:0]     r_rsp_mask;
  logic [ADDR_W-1:0]      r_rsp_addr;

  // Program store; contents are not touched by reset and start out as NOP_WORD.
  logic [15:0] r_mem [DEPTH] = '{default: NOP_WORD};

  // Returns {in_range, word} for one lane address; out-of-range lanes read as NOP.
  function automatic logic [16:0] lane_word(input logic [ADDR_W:0] la);
    logic [16:0] res;
    if (la < DEPTH_X) res = {1'b1, r_mem[la[IDX_W-1:0]]};
    else              res = {1'b0, NOP_WORD};
    return res;
  endfunction

  // Program load: write in-range addresses only, out-of-range loads are dropped.
  always_ff @(posedge i_clock) begin
    if (i_ld_en && ({1'b0, i_ld_addr} < DEPTH_X))
      r_mem[i_ld_addr[IDX_W-1:0]] <= i_ld_data;
  end

  // Gather the FETCH_W lanes starting at the request base address.
  always_comb begin
    logic [16:0] v_lane;
    w_fetch_data = '0;
    w_fetch_mask = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      v_lane = lane_word({1'b0, i_req_addr} + (ADDR_W+1)'(i));
      w_fetch_data[16*i +: 16] = v_lane[15:0];
      w_fetch_mask[i]          = v_lane[16];
    end
  end

  // State register: reset empties the response slot immediately.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_EMPTY;
    else            r_state <= w_state_nxt;
  end

  // Handshake and next state; flush wins over everything, loads block fetches.
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = i_reset_n && !i_ld_en && !i_flush &&
                  ((r_state == S_EMPTY) || i_rsp_ready);
    w_accept    = i_req_valid && o_req_ready;
    if (i_flush)
      w_state_nxt = S_EMPTY;
    else if (w_accept)
      w_state_nxt = S_FULL;
    else if ((r_state == S_FULL) && i_rsp_ready)
      w_state_nxt = S_EMPTY;
  end

  // Response registers: loaded only on accept, so a stalled response holds.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rsp_data <= {FETCH_W{NOP_WORD}};
      r_rsp_mask <= '0;
      r_rsp_addr <= '0;
    end else if (w_accept) begin
      r_rsp_data <= w_fetch_data;
      r_rsp_mask <= w_fetch_mask;
      r_rsp_addr <= i_req_addr;
    end
  end

  assign o_rsp_valid = (r_state == S_FULL);
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_mask  = r_rsp_mask;
  assign o_rsp_addr  = r_rsp_addr;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Bench for inst_fetch_mem: scoreboard of expected responses plus directed
// checks of reset, range boundaries, stall, streaming, flush and load blocking.
module tb_inst_fetch_mem;

  localparam int DEPTH = 256;
  localparam int AW    = 16;
  localparam int FW    = 2;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b1;
  logic            ld_en     = 1'b0;
  logic [AW-1:0]   ld_addr   = '0;
  logic [15:0]     ld_data   = '0;
  logic            req_valid = 1'b0;
  logic [AW-1:0]   req_addr  = '0;
  logic            req_ready;
  logic            flush     = 1'b0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [16*FW-1:0] rsp_data;
  logic [FW-1:0]   rsp_mask;
  logic [AW-1:0]   rsp_addr;

  typedef struct packed {
    logic [16*FW-1:0] data;
    logic [FW-1:0]    mask;
    logic [AW-1:0]    addr;
  } rsp_t;

  rsp_t        sb_q[$];
  logic [15:0] tb_mem [DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;

  inst_fetch_mem #(
    .DEPTH(DEPTH), .ADDR_W(AW), .FETCH_W(FW), .NOP_WORD(16'hFFFF)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
    .i_req_valid(req_valid), .i_req_addr(req_addr), .o_req_ready(req_ready),
    .i_flush(flush),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_mask(rsp_mask), .o_rsp_addr(rsp_addr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic rsp_t model_rsp(input logic [AW-1:0] a);
    rsp_t r;
    int   la;
    r.addr = a;
    r.mask = '0;
    r.data = '0;
    for (int i = 0; i < FW; i++) begin
      la = int'(a) + i;
      if (la < DEPTH) begin
        r.data[16*i +: 16] = tb_mem[la];
        r.mask[i]          = 1'b1;
      end else begin
        r.data[16*i +: 16] = 16'hFFFF;
      end
    end
    return r;
  endfunction

  // Monitor: compare the pending response, retire it, enqueue new accepts.
  always @(negedge clk) begin
    logic exp_ready;
    if (!rst_n) sb_q.delete();
    exp_ready = rst_n && !ld_en && !flush && ((sb_q.size() == 0) || rsp_ready);
    check_val("req_ready", {63'b0, req_ready}, {63'b0, exp_ready});
    check_val("rsp_valid", {63'b0, rsp_valid}, {63'b0, (sb_q.size() != 0)});
    if (sb_q.size() != 0) begin
      check_val("sb_data", 64'(rsp_data), 64'(sb_q[0].data));
      check_val("sb_mask", 64'(rsp_mask), 64'(sb_q[0].mask));
      check_val("sb_addr", 64'(rsp_addr), 64'(sb_q[0].addr));
      if (rsp_ready || flush) void'(sb_q.pop_front());
    end
    if (req_valid && exp_ready) sb_q.push_back(model_rsp(req_addr));
    if (ld_en && (int'(ld_addr) < DEPTH)) tb_mem[ld_addr] = ld_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    req_valid = 1'b1; req_addr = a;
    step();
    req_valid = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [31:0] d,
                           input logic [1:0] m, input logic [15:0] a);
    check_val({tag, "_valid"}, {63'b0, rsp_valid}, {63'b0, v});
    check_val({tag, "_data"},  64'(rsp_data), 64'(d));
    check_val({tag, "_mask"},  64'(rsp_mask), 64'(m));
    check_val({tag, "_addr"},  64'(rsp_addr), 64'(a));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = 16'hFFFF;

    // Reset with a request pending: outputs clear at once, no acceptance.
    #2 rst_n = 1'b0;
    req_valid = 1'b1; req_addr = 16'd5;
    #1;
    check_rsp("reset", 1'b0, 32'hFFFF_FFFF, 2'b00, 16'h0000);
    check_val("reset_ready", {63'b0, req_ready}, 64'd0);
    repeat (3) step();
    req_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Loads block fetches; then the basic two-word fetch.
    req_valid = 1'b1; req_addr = 16'd2;
    load(16'd2, 16'h3401);
    req_valid = 1'b0;
    load(16'd3, 16'h0011);
    rsp_ready = 1'b1;
    fetch(16'd2);
    check_rsp("fetch2", 1'b1, 32'h0011_3401, 2'b11, 16'd2);
    step();

    // End-of-store boundary and top-of-address-space without wrap.
    load(16'd255, 16'hABCD);
    load(16'd0, 16'h1234);
    fetch(16'd255);
    check_rsp("fetch255", 1'b1, 32'hFFFF_ABCD, 2'b01, 16'd255);
    fetch(16'hFFFF);
    check_rsp("fetchFFFF", 1'b1, 32'hFFFF_FFFF, 2'b00, 16'hFFFF);
    step();

    // Stall: response holds, new request waits, then is taken on release.
    rsp_ready = 1'b0;
    fetch(16'd8);
    req_valid = 1'b1; req_addr = 16'd10;
    for (int k = 0; k < 3; k++) begin
      check_val("stall_ready", {63'b0, req_ready}, 64'd0);
      check_val("stall_addr", 64'(rsp_addr), 64'd8);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check_val("release_ready", {63'b0, req_ready}, 64'd1);
    step();
    req_valid = 1'b0;
    check_val("release_addr", 64'(rsp_addr), 64'd10);
    step();

    // Back-to-back stream, one fetch per cycle.
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1; req_addr = AW'(2 * k);
      step();
      check_val("stream_valid", {63'b0, rsp_valid}, 64'd1);
      check_val("stream_addr", 64'(rsp_addr), 64'(2 * k));
    end
    req_valid = 1'b0;
    step();

    // Flush during a full cycle drops the response and blocks the request.
    rsp_ready = 1'b0;
    fetch(16'd12);
    flush = 1'b1; req_valid = 1'b1; req_addr = 16'd14;
    #1;
    check_val("flush_ready", {63'b0, req_ready}, 64'd0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    check_val("flush_valid", {63'b0, rsp_valid}, 64'd0);
    step();

    // Random traffic; loads stay clear of words 2 and 3.
    for (int k = 0; k < 400; k++) begin
      ld_en     = ($urandom_range(0, 7) == 0);
      ld_addr   = AW'($urandom_range(8, 300));
      ld_data   = 16'($urandom);
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(16'hFFF0, 16'hFFFF))
                                              : AW'($urandom_range(0, 300));
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    ld_en = 1'b0; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    repeat (2) step();

    // Reset mid-stall: valid drops without a clock edge, then fetch again.
    rsp_ready = 1'b0;
    fetch(16'd20);
    req_valid = 1'b1; req_addr = 16'd22;
    step();
    #2 rst_n = 1'b0;
    #1;
    check_rsp("midreset", 1'b0, 32'hFFFF_FFFF, 2'b00, 16'h0000);
    check_val("midreset_ready", {63'b0, req_ready}, 64'd0);
    step();
    rst_n = 1'b1; req_valid = 1'b0;
    step();
    rsp_ready = 1'b1;
    fetch(16'd2);
    check_rsp("postreset", 1'b1, 32'h0011_3401, 2'b11, 16'd2);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
